// File: rtl/riscv_pkg.sv
// Shared types for the memory-stage load/store unit.
// Load/store size codes, result-source encoding and LSU states.
package riscv_pkg;

  localparam logic [1:0] RES_MEM = 2'b01;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_type_e;

  typedef enum logic [1:0] {
    SB = 2'b00,
    SH = 2'b01,
    SW = 2'b10
  } store_size_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_load_extend.sv
// Load lane select and sign/zero extension.
// Unlisted load codes pass the raw word through.
module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      load_src_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata_i[{off_i, 3'b000} +: 8];
    h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (load_src_i)
      LB:      data_o = {{(XLEN-8){b[7]}}, b};
      LH:      data_o = {{(XLEN-16){h[15]}}, h};
      LBU:     data_o = {{(XLEN-8){1'b0}}, b};
      LHU:     data_o = {{(XLEN-16){1'b0}}, h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage LSU: req/ack data-memory port with byte enables,
// pipeline stall while outstanding, timeout abort and load extension.
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_write_m,
  input  logic [1:0]      result_src_m,
  input  logic [2:0]      load_src_m,
  input  logic [1:0]      store_size_m,
  input  logic [XLEN-1:0] alu_result_m,
  input  logic [XLEN-1:0] write_data_m,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_m,
  output logic [XLEN-1:0] load_data_m,
  output logic            misaligned_m,
  output logic            bus_err_m
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] ld_q, ld_d;
  logic [3:0]      be_q, be_d;
  logic            we_q, we_d;
  logic            is_ld_q, is_ld_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      lsrc_q, lsrc_d;
  logic            err_q, err_d;

  logic            access, is_ld, is_byte, is_half, aligned;
  logic            stall, mis;
  logic [1:0]      off;
  logic [3:0]      be_n;
  logic [XLEN-1:0] wdata_n, ext;

  assign off    = alu_result_m[1:0];
  assign access = mem_write_m || (result_src_m == RES_MEM);
  assign is_ld  = (result_src_m == RES_MEM) && !mem_write_m;

  // Store size wins when both a store and a load are flagged.
  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    if (mem_write_m) begin
      is_byte = (store_size_m == SB);
      is_half = (store_size_m == SH);
    end else begin
      is_byte = (load_src_m == LB) || (load_src_m == LBU);
      is_half = (load_src_m == LH) || (load_src_m == LHU);
    end
    aligned = is_byte || (is_half ? !off[0] : (off == 2'b00));
  end

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = write_data_m;
    unique case (1'b1)
      is_byte: begin
        be_n    = 4'b0001 << off;
        wdata_n = {4{write_data_m[7:0]}};
      end
      is_half: begin
        be_n    = 4'b0011 << {off[1], 1'b0};
        wdata_n = {2{write_data_m[15:0]}};
      end
      default: ;
    endcase
  end

  load_extend #(.XLEN(XLEN)) u_ext (
    .rdata_i    (dmem_rdata),
    .off_i      (off_q),
    .load_src_i (lsrc_q),
    .data_o     (ext)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    is_ld_d = is_ld_q;
    off_d   = off_q;
    lsrc_d  = lsrc_q;
    ld_d    = ld_q;
    err_d   = 1'b0;
    stall   = 1'b0;
    mis     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access && aligned) begin
          stall   = 1'b1;
          addr_d  = {alu_result_m[XLEN-1:2], 2'b00};
          wdata_d = wdata_n;
          be_d    = be_n;
          we_d    = mem_write_m;
          is_ld_d = is_ld;
          off_d   = off;
          lsrc_d  = load_src_m;
          cnt_d   = '0;
          ld_d    = '0;
          state_d = REQ;
        end else if (access) begin
          mis  = 1'b1;
          ld_d = '0;
        end
      end
      REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (dmem_ack) begin
          if (is_ld_q) ld_d = ext;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          ld_d    = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      is_ld_q <= 1'b0;
      off_q   <= '0;
      lsrc_q  <= '0;
      ld_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      is_ld_q <= is_ld_d;
      off_q   <= off_d;
      lsrc_q  <= lsrc_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
    end
  end

  assign dmem_req     = (state_q == REQ);
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign stall_m      = stall && !reset;
  assign misaligned_m = mis && !reset;
  assign bus_err_m    = err_q;
  assign load_data_m  = mis ? '0 : ld_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu against a transaction-level model.
// Directed cases cover the listed corner cases, then random traffic.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write_m;
  logic [1:0]  result_src_m;
  logic [2:0]  load_src_m;
  logic [1:0]  store_size_m;
  logic [31:0] alu_result_m;
  logic [31:0] write_data_m;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_m;
  logic [31:0] load_data_m;
  logic        misaligned_m;
  logic        bus_err_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_write_m  (mem_write_m),
    .result_src_m (result_src_m),
    .load_src_m   (load_src_m),
    .store_size_m (store_size_m),
    .alu_result_m (alu_result_m),
    .write_data_m (write_data_m),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .stall_m      (stall_m),
    .load_data_m  (load_data_m),
    .misaligned_m (misaligned_m),
    .bus_err_m    (bus_err_m)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [2:0] ls,
                                           input logic [31:0] rd,
                                           input logic [1:0] a);
    logic [31:0] w;
    w = rd >> (8 * a);
    case (ls)
      3'd0:    return {{24{w[7]}}, w[7:0]};
      3'd1:    return {{16{w[15]}}, w[15:0]};
      3'd4:    return {24'd0, w[7:0]};
      3'd5:    return {16'd0, w[15:0]};
      default: return rd;
    endcase
  endfunction

  task automatic drive_idle(input bit ack);
    mem_write_m  = 1'b0;
    result_src_m = 2'(($urandom % 3) == 0 ? 2'b00 : 2'b10);
    dmem_ack     = ack;
    dmem_rdata   = $urandom;
  endtask

  task automatic idle_cycle(input bit ack);
    @(negedge clk);
    drive_idle(ack);
    #1;
    chk("idle_req", {31'd0, dmem_req}, 0);
    chk("idle_stall", {31'd0, stall_m}, 0);
    chk("idle_err", {31'd0, bus_err_m}, 0);
  endtask

  // dly: REQ cycle index (0-based) carrying the ack, -1 for none.
  task automatic do_access(input bit st, input bit ld, input logic [2:0] code,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int dly);
    int n;
    logic [3:0] ebe;
    logic [31:0] ewd, eld;
    bit is_ld;
    is_ld = !st && ld;
    if (st) n = (code[1:0] == 2'd0) ? 1 : (code[1:0] == 2'd1) ? 2 : 4;
    else n = (code == 3'd0 || code == 3'd4) ? 1 :
             (code == 3'd1 || code == 3'd5) ? 2 : 4;
    ebe = 4'(((1 << n) - 1) << a[1:0]);
    for (int i = 0; i < 4; i++) ewd[8*i +: 8] = wd[8*(i % n) +: 8];
    eld = exp_load(code, rd, a[1:0]);

    @(negedge clk);
    mem_write_m  = st;
    result_src_m = ld ? 2'b01 : 2'b00;
    load_src_m   = code;
    store_size_m = code[1:0];
    alu_result_m = a;
    write_data_m = wd;
    dmem_ack     = 1'b0;
    #1;
    if ((a % n) != 0) begin
      chk("mis_pulse", {31'd0, misaligned_m}, 1);
      chk("mis_stall", {31'd0, stall_m}, 0);
      chk("mis_req", {31'd0, dmem_req}, 0);
      chk("mis_ld", load_data_m, 0);
      @(negedge clk);
      drive_idle(1'b0);
      #1;
      chk("mis_req2", {31'd0, dmem_req}, 0);
      chk("mis_end", {31'd0, misaligned_m}, 0);
      return;
    end
    chk("go_stall", {31'd0, stall_m}, 1);
    chk("go_req", {31'd0, dmem_req}, 0);
    chk("go_mis", {31'd0, misaligned_m}, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("req", {31'd0, dmem_req}, 1);
      chk("req_stall", {31'd0, stall_m}, 1);
      chk("req_we", {31'd0, dmem_we}, {31'd0, st});
      chk("req_addr", dmem_addr, {a[31:2], 2'b00});
      chk("req_be", {28'd0, dmem_be}, {28'd0, ebe});
      if (st) chk("req_wdata", dmem_wdata, ewd);
      if (k == dly) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rd;
        break;
      end
      dmem_rdata = $urandom;
    end
    @(negedge clk);
    dmem_ack   = 1'b0;
    dmem_rdata = $urandom;
    #1;
    chk("done_stall", {31'd0, stall_m}, 0);
    chk("done_req", {31'd0, dmem_req}, 0);
    if (dly < 0) begin
      chk("tmo_err", {31'd0, bus_err_m}, 1);
      chk("tmo_ld", load_data_m, 0);
    end else begin
      chk("done_err", {31'd0, bus_err_m}, 0);
      if (is_ld) chk("load_data", load_data_m, eld);
    end
  endtask

  initial begin
    bit st, ld;
    logic [2:0] code;
    int dly;
    reset        = 1'b1;
    mem_write_m  = 1'b0;
    result_src_m = 2'b00;
    load_src_m   = 3'd0;
    store_size_m = 2'd0;
    alu_result_m = '0;
    write_data_m = '0;
    dmem_ack     = 1'b0;
    dmem_rdata   = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, dmem_req}, 0);
    chk("rst_we", {31'd0, dmem_we}, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_be", {28'd0, dmem_be}, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_ld", load_data_m, 0);
    chk("rst_stall", {31'd0, stall_m}, 0);
    chk("rst_mis", {31'd0, misaligned_m}, 0);
    chk("rst_err", {31'd0, bus_err_m}, 0);
    reset = 1'b0;

    do_access(0, 1, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    idle_cycle(0);
    do_access(1, 0, 3'd0, 32'h103, 32'hA5, 32'h0, 0);
    idle_cycle(0);
    do_access(0, 1, 3'd0, 32'h102, 32'h0, 32'h00800000, 1);
    do_access(0, 1, 3'd4, 32'h102, 32'h0, 32'h00800000, 0);
    do_access(0, 1, 3'd1, 32'h102, 32'h0, 32'h80000000, 2);
    do_access(1, 0, 3'd1, 32'h101, 32'h1234, 32'h0, 0);
    do_access(0, 1, 3'd2, 32'h104, 32'h0, 32'h11111111, -1);
    idle_cycle(0);
    do_access(0, 1, 3'd2, 32'h108, 32'h0, 32'hCAFEF00D, 3);
    do_access(1, 1, 3'd2, 32'h10C, 32'h89ABCDEF, 32'h0, 0);
    idle_cycle(1);
    idle_cycle(0);

    // Reset in the first REQ cycle, stray ack one cycle later.
    @(negedge clk);
    mem_write_m  = 1'b0;
    result_src_m = 2'b01;
    load_src_m   = 3'd2;
    alu_result_m = 32'h300;
    #1;
    chk("rr_stall", {31'd0, stall_m}, 1);
    @(negedge clk);
    #1;
    chk("rr_req", {31'd0, dmem_req}, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive_idle(1'b1);
    dmem_rdata = 32'hFFFFFFFF;
    #1;
    chk("rr_req0", {31'd0, dmem_req}, 0);
    chk("rr_ld0", load_data_m, 0);
    @(negedge clk);
    drive_idle(1'b0);
    #1;
    chk("rr_req1", {31'd0, dmem_req}, 0);
    chk("rr_stall1", {31'd0, stall_m}, 0);
    chk("rr_ld1", load_data_m, 0);
    do_access(0, 1, 3'd5, 32'h302, 32'h0, 32'h9876ABCD, 0);

    for (int t = 0; t < 60; t++) begin
      st   = 1'($urandom % 2);
      ld   = st ? 1'($urandom % 2) : 1'b1;
      code = 3'($urandom % 8);
      dly  = (($urandom % 8) == 0) ? -1 : int'($urandom % 4);
      do_access(st, ld, code, 32'h200 + ($urandom % 64), $urandom,
                $urandom, dly);
      if (($urandom % 3) == 0) idle_cycle(1'($urandom % 2));
    end
    idle_cycle(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
